// File: rtl/load_store_unit_if.sv
// load_store_unit_if: request/response handshake and word-memory bus of the load/store unit.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wren;
  logic [31:0] mem_rdata;
  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, resp_ready, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_wren
  );
  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, resp_ready, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_wren
  );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: byte/half/word loads and stores onto a word-wide memory,
// sub-word stores done as read-modify-write.
module load_store_unit (
  input logic clk,
  input logic rst,
  load_store_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
  state_t      r_state, w_next;
  logic [31:0] r_addr, r_word, r_rdata;
  logic [15:0] r_wdata;
  logic [1:0]  r_size;
  logic        r_signed, r_write, r_err;
  logic        w_acc, w_err;
  logic [4:0]  w_bsh, w_hsh;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ext, w_mask, w_ins, w_merge;
  assign w_acc = bus.req_valid && r_state == IDLE;
  assign w_err = bus.req_size == 2'b11 || (bus.req_size == 2'b01 && bus.req_addr[0]) ||
                 (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00);
  assign w_bsh = {r_addr[1:0], 3'b000};
  assign w_hsh = {r_addr[1], 4'b0000};
  assign w_byte = 8'(bus.mem_rdata >> w_bsh);
  assign w_half = 16'(bus.mem_rdata >> w_hsh);
  assign w_ext = r_size == 2'b00 ? {{24{r_signed & w_byte[7]}}, w_byte} :
                 r_size == 2'b01 ? {{16{r_signed & w_half[15]}}, w_half} : bus.mem_rdata;
  assign w_mask = r_size == 2'b00 ? 32'h0000_00ff << w_bsh : 32'h0000_ffff << w_hsh;
  assign w_ins = r_size == 2'b00 ? {24'h0, r_wdata[7:0]} << w_bsh : {16'h0, r_wdata} << w_hsh;
  assign w_merge = (bus.mem_rdata & ~w_mask) | (w_ins & w_mask);
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  if (bus.req_valid) w_next = w_err ? RESP : (bus.req_write && bus.req_size == 2'b10) ? WRITE : READ;
      READ:  w_next = r_write ? WRITE : RESP;
      WRITE: w_next = RESP;
      RESP:  if (bus.resp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  // r_word holds the full store word: req_wdata for word stores, the merged word after READ otherwise
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_addr   <= '0;
      r_wdata  <= '0;
      r_size   <= '0;
      r_signed <= 1'b0;
      r_write  <= 1'b0;
      r_word   <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else if (w_acc) begin
      r_addr   <= bus.req_addr;
      r_wdata  <= bus.req_wdata[15:0];
      r_size   <= bus.req_size;
      r_signed <= bus.req_signed;
      r_write  <= bus.req_write;
      r_word   <= bus.req_wdata;
      r_rdata  <= '0;
      r_err    <= w_err;
    end else if (r_state == READ) begin
      if (r_write) r_word  <= w_merge;
      else         r_rdata <= w_ext;
    end
  assign bus.req_ready  = r_state == IDLE;
  assign bus.resp_valid = r_state == RESP;
  assign bus.resp_rdata = r_rdata;
  assign bus.resp_err   = r_err;
  assign bus.mem_addr   = (r_state == READ || r_state == WRITE) ? {r_addr[31:2], 2'b00} : 32'h0;
  assign bus.mem_wdata  = r_state == WRITE ? r_word : 32'h0;
  assign bus.mem_wren   = r_state == WRITE ? 4'hf : 4'h0;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: scoreboard bench with a word memory model and an independent byte-lane reference.
module tb_load_store_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  load_store_unit_if bus ();
  load_store_unit dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [3:0]  lat;
    logic [3:0]  wr;
    logic [31:0] wword;
  } exp_t;
  exp_t        q[$];
  logic [31:0] mem [0:1023];
  logic [31:0] exp_mem [0:1023];
  int          n_checks = 0;
  int          n_fail = 0;
  assign bus.mem_rdata = mem[bus.mem_addr[11:2]];
  always @(posedge clk) if (bus.mem_wren == 4'hf) mem[bus.mem_addr[11:2]] <= bus.mem_wdata;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask
  task automatic model(input logic w, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                       input logic [31:0] wd, output exp_t e);
    logic [7:0]  b [4];
    logic [31:0] word;
    logic [15:0] h;
    int          k;
    k = int'(a[1:0]);
    word = exp_mem[a[11:2]];
    for (int i = 0; i < 4; i++) b[i] = word[8*i +: 8];
    e = '0;
    e.err = sz == 2'd3 || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
    if (e.err) e.lat = 4'd1;
    else if (!w) begin
      e.lat = 4'd2;
      h = {b[k | 1], b[k & 2]};
      if (sz == 2'd0)      e.rdata = sg ? 32'($signed(b[k])) : {24'h0, b[k]};
      else if (sz == 2'd1) e.rdata = sg ? 32'($signed(h)) : {16'h0, h};
      else                 e.rdata = word;
    end else begin
      e.wr = 4'd1;
      e.lat = sz == 2'd2 ? 4'd2 : 4'd3;
      if (sz == 2'd0) b[k] = wd[7:0];
      else if (sz == 2'd1) begin
        b[k & 2] = wd[7:0];
        b[k | 1] = wd[15:8];
      end
      word = sz == 2'd2 ? wd : {b[3], b[2], b[1], b[0]};
      e.wword = word;
      exp_mem[a[11:2]] = word;
    end
  endtask
  // called at a negedge with the DUT idle; returns at a negedge with the DUT idle again
  task automatic do_req(input logic w, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                        input logic [31:0] wd, input int hold);
    exp_t e, f;
    int   lat, wr;
    model(w, sz, sg, a, wd, e);
    q.push_back(e);
    check("req_ready_idle", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1; bus.req_write = w; bus.req_size = sz; bus.req_signed = sg;
    bus.req_addr = a; bus.req_wdata = wd;
    @(posedge clk);
    #1;
    bus.req_valid = 1'($urandom); bus.req_write = 1'($urandom); bus.req_size = 2'($urandom);
    bus.req_signed = 1'($urandom); bus.req_addr = $urandom; bus.req_wdata = $urandom;
    lat = 1; wr = 0;
    @(negedge clk);
    while (!bus.resp_valid && lat < 10) begin
      check("req_ready_busy", 32'(bus.req_ready), 32'd0);
      if (bus.mem_wren != 4'h0) begin
        wr++;
        check("mem_wren", 32'(bus.mem_wren), 32'hf);
        check("mem_wdata", bus.mem_wdata, e.wword);
        check("mem_addr", bus.mem_addr, {a[31:2], 2'b00});
      end
      @(posedge clk); lat++; @(negedge clk);
    end
    check("latency", 32'(lat), 32'(e.lat));
    for (int n = 0; n < hold; n++) begin
      check("resp_hold_valid", 32'(bus.resp_valid), 32'd1);
      check("resp_hold_ready", 32'(bus.req_ready), 32'd0);
      check("resp_hold_rdata", bus.resp_rdata, q[0].rdata);
      check("resp_hold_wren", 32'(bus.mem_wren), 32'd0);
      @(posedge clk); @(negedge clk);
    end
    bus.req_valid = 1'b0;
    bus.resp_ready = 1'b1;
    check("resp_valid", 32'(bus.resp_valid), 32'd1);
    f = q.pop_front();
    check("resp_rdata", bus.resp_rdata, f.rdata);
    check("resp_err", 32'(bus.resp_err), 32'(f.err));
    check("write_pulses", 32'(wr), 32'(f.wr));
    @(posedge clk);
    #1 bus.resp_ready = 1'b0;
    @(negedge clk);
    check("req_ready_after", 32'(bus.req_ready), 32'd1);
    check("resp_valid_after", 32'(bus.resp_valid), 32'd0);
  endtask
  initial begin
    int diffs;
    logic [1:0] sz;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'd0; bus.req_signed = 1'b0;
    bus.req_addr = '0; bus.req_wdata = '0; bus.resp_ready = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    mem[10'h40] = 32'h8899aabb;
    mem[10'h80] = 32'h0;
    for (int i = 0; i < 1024; i++) exp_mem[i] = mem[i];
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_rdata", bus.resp_rdata, 32'd0);
    check("rst_resp_err", 32'(bus.resp_err), 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    check("rst_mem_wdata", bus.mem_wdata, 32'd0);
    check("rst_mem_wren", 32'(bus.mem_wren), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    do_req(1'b0, 2'd0, 1'b1, 32'h102, 32'h0, 0);
    do_req(1'b1, 2'd0, 1'b0, 32'h101, 32'h5c, 0);
    check("rmw_image", mem[10'h40], 32'h88995cbb);
    do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 0);
    do_req(1'b0, 2'd1, 1'b0, 32'h103, 32'h0, 0);
    do_req(1'b1, 2'd2, 1'b0, 32'h200, 32'hdeadbeef, 5);
    check("word_store_image", mem[10'h80], 32'hdeadbeef);
    // reset during the WRITE cycle of a word store
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'd2;
    bus.req_addr = 32'h300; bus.req_wdata = 32'hcafef00d;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_wren", 32'(bus.mem_wren), 32'hf);
    rst = 1'b1;
    #1;
    check("async_rst_wren", 32'(bus.mem_wren), 32'd0);
    check("async_rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("async_rst_req_ready", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("post_rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("post_rst_mem", mem[10'hc0], exp_mem[10'hc0]);
    for (int i = 0; i < 60; i++) begin
      sz = 2'($urandom);
      do_req(1'($urandom), sz, 1'($urandom), 32'h100 + 32'($urandom_range(0, 63)), $urandom,
             $urandom_range(0, 3));
    end
    diffs = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== exp_mem[i]) diffs++;
    check("mem_image_diffs", 32'(diffs), 32'd0);
    check("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
